// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: ALU opcodes, arbiter FSM states, datapath width.
package alu_pkg;
  localparam int ALU_DW = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_NOT = 3'd2,
    ALU_LS  = 3'd3,
    ALU_RS  = 3'd4,
    ALU_AND = 3'd5,
    ALU_OR  = 3'd6,
    ALU_LT  = 3'd7
  } alu_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the shared-ALU arbiter.
interface alu_arbiter_if import alu_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DW   = ALU_DW,
  parameter int IDW  = 2,
  parameter int CNTW = 16
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*3-1:0]  req_sel;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  alu_sel_t           alu_sel;
  logic [DW-1:0]      alu_a;
  logic [DW-1:0]      alu_b;
  logic [DW-1:0]      alu_out;
  logic               busy;
  logic [CNTW-1:0]    op_count;

  modport slave (
    input  req_valid, req_sel, req_a, req_b, rsp_ready, alu_out,
    output req_ready, rsp_valid, rsp_id, rsp_data, alu_sel, alu_a, alu_b, busy, op_count
  );

  modport master (
    output req_valid, req_sel, req_a, req_b, rsp_ready, alu_out,
    input  req_ready, rsp_valid, rsp_id, rsp_data, alu_sel, alu_a, alu_b, busy, op_count
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_gnt_idx,
  output logic            o_any
);
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[j]) begin
        o_gnt[j]  = 1'b1;
        o_gnt_idx = IDW'(j);
        o_any     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters: grant, execute, then hold the
// tagged result on a valid/ready channel until taken.
module alu_arbiter import alu_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DW   = ALU_DW,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  arb_state_t      r_state, w_state_nxt;
  logic [IDW-1:0]  r_ptr, w_gnt_idx, r_id;
  logic [NREQ-1:0] w_gnt, w_req_ready;
  logic            w_any, r_rsp_valid;
  alu_sel_t        r_sel;
  logic [DW-1:0]   r_a, r_b, r_data;
  logic [CNTW-1:0] r_cnt;
  int              w_gi;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .i_req     (bus.req_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_gi = int'(w_gnt_idx);

  // No grant is shown while reset is held, so nobody believes it was accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    case (r_state)
      IDLE: if (w_any && !rst) begin
        w_req_ready = w_gnt;
        w_state_nxt = EXEC;
      end
      EXEC:    w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_sel       <= ALU_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_data      <= '0;
      r_rsp_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (w_any) begin
          r_sel <= alu_sel_t'(bus.req_sel[3*w_gi +: 3]);
          r_a   <= bus.req_a[DW*w_gi +: DW];
          r_b   <= bus.req_b[DW*w_gi +: DW];
          r_id  <= w_gnt_idx;
          r_ptr <= (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
        end
        EXEC: begin
          r_data      <= bus.alu_out;
          r_rsp_valid <= 1'b1;
        end
        RESP: if (bus.rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_cnt       <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_data;
  assign bus.alu_sel   = r_sel;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.busy      = (r_state != IDLE);
  assign bus.op_count  = r_cnt;
endmodule
